// File: rtl/tlp_tx_arb.sv
// Packet-granular round-robin arbiter merging two TLP streams onto the PCIe core TX port,
// with stall-triggered discontinue and power-down (turn-off) handshake.
module tlp_tx_arb #(
  parameter int STALL_LIMIT = 32,
  parameter int DSC_CNT_W   = 16
) (
  input  logic                 user_clk,
  input  logic                 sys_rst_n,
  input  logic [63:0]          src0_tdata,
  input  logic [7:0]           src0_tkeep,
  input  logic                 src0_tlast,
  input  logic                 src0_tvalid,
  output logic                 src0_tready,
  input  logic [63:0]          src1_tdata,
  input  logic [7:0]           src1_tkeep,
  input  logic                 src1_tlast,
  input  logic                 src1_tvalid,
  output logic                 src1_tready,
  input  logic                 s_axis_tx_tready,
  output logic [63:0]          s_axis_tx_tdata,
  output logic [7:0]           s_axis_tx_tkeep,
  output logic                 s_axis_tx_tlast,
  output logic                 s_axis_tx_tvalid,
  output logic                 tx_src_dsc,
  input  logic                 cfg_to_turnoff,
  output logic                 cfg_turnoff_ok,
  output logic [1:0]           grant,
  output logic [DSC_CNT_W-1:0] dsc_count
);

  localparam int STALL_W = $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

  typedef enum logic [2:0] {
    IDLE, GRANT0, GRANT1, DSC, DROP0, DROP1, TURNOFF
  } state_t;

  state_t               state, state_nxt;
  logic                 last_grant, last_grant_nxt;
  logic                 dsc_src, dsc_src_nxt;
  logic                 beat_seen, beat_seen_nxt;
  logic [STALL_W-1:0]   stall_cnt, stall_cnt_nxt;
  logic [DSC_CNT_W-1:0] dsc_cnt_nxt;

  // Source currently owning the TX port while in a GRANT state.
  logic        cur_src;
  logic [63:0] cur_tdata;
  logic [7:0]  cur_tkeep;
  logic        cur_tlast;
  logic        cur_tvalid;

  assign cur_src    = (state == GRANT1);
  assign cur_tdata  = cur_src ? src1_tdata  : src0_tdata;
  assign cur_tkeep  = cur_src ? src1_tkeep  : src0_tkeep;
  assign cur_tlast  = cur_src ? src1_tlast  : src0_tlast;
  assign cur_tvalid = cur_src ? src1_tvalid : src0_tvalid;

  always_ff @(posedge user_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      dsc_src    <= 1'b0;
      beat_seen  <= 1'b0;
      stall_cnt  <= '0;
      dsc_count  <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      dsc_src    <= dsc_src_nxt;
      beat_seen  <= beat_seen_nxt;
      stall_cnt  <= stall_cnt_nxt;
      dsc_count  <= dsc_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    last_grant_nxt   = last_grant;
    dsc_src_nxt      = dsc_src;
    beat_seen_nxt    = beat_seen;
    stall_cnt_nxt    = stall_cnt;
    dsc_cnt_nxt      = dsc_count;
    s_axis_tx_tdata  = '0;
    s_axis_tx_tkeep  = '0;
    s_axis_tx_tlast  = 1'b0;
    s_axis_tx_tvalid = 1'b0;
    tx_src_dsc       = 1'b0;
    src0_tready      = 1'b0;
    src1_tready      = 1'b0;
    cfg_turnoff_ok   = 1'b0;
    grant            = 2'b00;

    case (state)
      IDLE: begin
        stall_cnt_nxt = '0;
        beat_seen_nxt = 1'b0;
        if (cfg_to_turnoff) begin
          state_nxt = TURNOFF;
        end else if (src0_tvalid && (!src1_tvalid || last_grant)) begin
          state_nxt = GRANT0;
        end else if (src1_tvalid) begin
          state_nxt = GRANT1;
        end
      end

      GRANT0, GRANT1: begin
        s_axis_tx_tdata  = cur_tdata;
        s_axis_tx_tkeep  = cur_tkeep;
        s_axis_tx_tlast  = cur_tlast;
        s_axis_tx_tvalid = cur_tvalid;
        src0_tready      = !cur_src && s_axis_tx_tready;
        src1_tready      = cur_src && s_axis_tx_tready;
        grant            = cur_src ? 2'b10 : 2'b01;
        if (cur_tvalid) begin
          stall_cnt_nxt = '0;
          if (s_axis_tx_tready) begin
            beat_seen_nxt = 1'b1;
            if (cur_tlast) begin
              state_nxt      = IDLE;
              last_grant_nxt = cur_src;
            end
          end
        end else if (stall_cnt >= STALL_MAX - 1'b1) begin
          // A packet that never started is simply released; a started one must be terminated.
          stall_cnt_nxt  = STALL_MAX;
          last_grant_nxt = cur_src;
          dsc_src_nxt    = cur_src;
          state_nxt      = beat_seen ? DSC : IDLE;
        end else begin
          stall_cnt_nxt = stall_cnt + 1'b1;
        end
      end

      DSC: begin
        s_axis_tx_tvalid = 1'b1;
        s_axis_tx_tlast  = 1'b1;
        s_axis_tx_tkeep  = 8'hFF;
        tx_src_dsc       = 1'b1;
        if (s_axis_tx_tready) begin
          if (dsc_count != '1) dsc_cnt_nxt = dsc_count + 1'b1;
          state_nxt = dsc_src ? DROP1 : DROP0;
        end
      end

      DROP0: begin
        src0_tready = 1'b1;
        grant       = 2'b01;
        if (src0_tvalid && src0_tlast) state_nxt = IDLE;
      end

      DROP1: begin
        src1_tready = 1'b1;
        grant       = 2'b10;
        if (src1_tvalid && src1_tlast) state_nxt = IDLE;
      end

      TURNOFF: begin
        cfg_turnoff_ok = 1'b1;
        if (!cfg_to_turnoff) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/tlp_tx_arb.md
TLP_TX_ARB -- requirements
Module: tlp_tx_arb

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 32: consecutive idle source cycles mid-packet before the block discontinues the packet.
REQ-002 SHALL have parameter DSC_CNT_W, default 16: width of dsc_count.
REQ-003 SHALL use one clock, user_clk (input, 1): all state is updated on its rising edge.
REQ-004 SHALL use sys_rst_n (input, 1): reset is asynchronous and active-low.
REQ-005 SHALL have src0_tdata/src0_tkeep/src0_tlast/src0_tvalid (inputs, 64/8/1/1): requester 0 TLP stream (PIO completer).
REQ-006 SHALL have src0_tready (output, 1): the block accepts a src0 beat.
REQ-007 SHALL have src1_tdata/src1_tkeep/src1_tlast/src1_tvalid (inputs, 64/8/1/1) and src1_tready (output, 1): requester 1 TLP stream (remote-memory engine).
REQ-008 SHALL have s_axis_tx_tready (input, 1): PCIe core TX accepts a beat.
REQ-009 SHALL have s_axis_tx_tdata/tkeep/tlast/tvalid (outputs, 64/8/1/1) and tx_src_dsc (output, 1): PCIe core TX stream.
REQ-010 SHALL have cfg_to_turnoff (input, 1) and cfg_turnoff_ok (output, 1): core power-down handshake.
REQ-011 SHALL have grant (output, 2): one-hot current owner; 00 = none.
REQ-012 SHALL have dsc_count (output, DSC_CNT_W): saturating count of discontinued packets.

Function
REQ-013 SHALL implement the states IDLE, GRANT0, GRANT1, DSC, DROP0, DROP1 and TURNOFF.
REQ-014 IDLE SHALL select in this order: cfg_to_turnoff=1 -> TURNOFF; only srcN_tvalid -> GRANTN; both valid -> the source not granted last; none -> stay. The last-granted register SHALL reset to 1, so src0 wins the first tie.
REQ-015 IDLE SHALL transfer no data: s_axis_tx_tvalid=0 and both srcN_tready=0, giving one cycle of grant latency.
REQ-016 GRANTN SHALL pass data through combinationally with zero latency:
  - s_axis_tx_{tdata,tkeep,tlast,tvalid} = srcN_*;
  - srcN_tready = s_axis_tx_tready;
  - the other source's tready = 0;
  - tx_src_dsc = 0.
REQ-017 GRANTN SHALL return to IDLE on the cycle after a beat with srcN_tvalid&tready&tlast, and SHALL update last-granted to N.
REQ-018 Packet granularity: ownership SHALL never change mid-packet, and cfg_to_turnoff SHALL be ignored until the packet ends.
REQ-019 Stall counter:
  - clears on grant and on any cycle with srcN_tvalid=1;
  - increments on each GRANTN cycle with srcN_tvalid=0;
  - saturates at STALL_LIMIT.
REQ-020 When the stall counter reaches STALL_LIMIT with at least one beat already transferred in the packet, the block SHALL go to DSC.
REQ-021 When the stall counter reaches STALL_LIMIT with no beat yet transferred, the block SHALL go to IDLE with no discontinue.
REQ-022 DSC SHALL drive s_axis_tx_tvalid=1, tlast=1, tx_src_dsc=1, tkeep=8'hFF and tdata=0, with both srcN_tready=0.
REQ-023 DSC SHALL hold those values until s_axis_tx_tready=1, then increment dsc_count (saturating at all-ones) and go to DROPN.
REQ-024 DROPN SHALL hold srcN_tready=1 and s_axis_tx_tvalid=0, discarding beats.
REQ-025 DROPN SHALL go to IDLE after a beat with srcN_tvalid&tlast.
REQ-026 The source that stalled SHALL be recorded as last-granted.
REQ-027 TURNOFF SHALL drive cfg_turnoff_ok=1, grant=00 and no traffic.
REQ-028 TURNOFF SHALL go to IDLE when cfg_to_turnoff=0.
REQ-029 In every state other than TURNOFF, cfg_turnoff_ok SHALL be 0.
REQ-030 grant SHALL be 01 in GRANT0/DROP0, 10 in GRANT1/DROP1, and 00 otherwise.
REQ-031 s_axis_tx_tvalid SHALL be 0 in every state other than GRANTN and DSC.

Reset
REQ-032 While sys_rst_n=0, the block SHALL hold:
  - state=IDLE, last-granted=1, stall counter=0, dsc_count=0;
  - s_axis_tx_tvalid=0, tlast=0, tx_src_dsc=0, tdata=0, tkeep=0;
  - src0_tready=0, src1_tready=0, grant=00, cfg_turnoff_ok=0.
REQ-033 Reset asserted mid-packet SHALL abandon the packet immediately with no discontinue beat.
REQ-034 After reset release, arbitration SHALL restart from IDLE.

Verification
REQ-035 Both sources present 3-beat packets continuously with tready=1 -> output alternates src0, src1, src0, ... with one idle cycle between packets; grant toggles 01/10.
REQ-036 src0 sends 2 beats, then drops tvalid for 32 cycles -> one beat out with tlast=1, tx_src_dsc=1, tdata=0; dsc_count=1; src0's remaining beats up to tlast are consumed with tvalid=0 on the output; the next grant goes to src1 if it is valid.
REQ-037 cfg_to_turnoff rises during beat 2 of a 4-beat src1 packet -> the packet completes; cfg_turnoff_ok=1 two cycles after tlast; pending src0 is held off (tready=0) until cfg_to_turnoff falls.
REQ-038 Backpressure: s_axis_tx_tready toggles every cycle during src1 packets -> data and tkeep are unchanged while stalled, no beat is lost or duplicated, and the per-packet beat count matches.
REQ-039 sys_rst_n pulses low mid-packet on src0 -> outputs return to reset values asynchronously; after release, with both sources valid, src0 is granted first.
REQ-040 src1 is granted but never asserts tvalid for 32 cycles -> return to IDLE, tx_src_dsc stays 0, dsc_count is unchanged.
